// File: rtl/mmio_chk_pkg.sv
// ============================================================================
// Module      : mmio_chk_pkg
// Description : Shared types and constants for the MMIO store-to-output
//               latency checker (channel FSM states, address defaults,
//               latency counter width).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmio_chk_pkg;

  // Per-channel check state
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } chan_state_e;

  localparam logic [31:0] c_def_base_addr = 32'h0000_7000;
  localparam logic [31:0] c_def_stride    = 32'h0000_0010;

  // Width of the settle-latency counter and of o_worst_lat (window 1..15)
  localparam int c_lat_w = 4;

endpackage : mmio_chk_pkg

`default_nettype wire

// File: rtl/mmio_chk_chan.sv
// ============================================================================
// Module      : mmio_chk_chan
// Description : One channel of the latency checker. Captures the data of an
//               addressed store, then watches the observed peripheral output
//               for up to MAX_LAT edges. Reports a settle (with its latency)
//               or a timeout as single-cycle events for the top to aggregate.
// Ports       : i_clk, i_rst_n      clock / async active-low reset
//               i_clr               synchronous abort of any pending check
//               i_store, i_wdata    decoded store to this channel + its data
//               i_obs               observed output of this channel
//               o_match, o_lat      settled at this edge, latency 1..MAX_LAT
//               o_late              timed out at this edge
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_chk_chan
  import mmio_chk_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MAX_LAT = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_store,
  input  logic [DATA_W-1:0]  i_wdata,
  input  logic [DATA_W-1:0]  i_obs,
  output logic               o_match,
  output logic               o_late,
  output logic [c_lat_w-1:0] o_lat
);

  // lat_q holds (edges since the store - 1), so the last allowed edge is
  // reached when lat_q equals MAX_LAT-1.
  localparam logic [c_lat_w-1:0] c_last = c_lat_w'(MAX_LAT - 1);

  chan_state_e        state_q;
  logic [DATA_W-1:0]  data_q;
  logic [c_lat_w-1:0] lat_q;
  logic               w_cmp;
  logic               w_eq;

  // A new store or a clear supersedes any outcome of the current check.
  assign w_cmp   = (state_q == WAIT) && !i_store && !i_clr;
  assign w_eq    = (i_obs == data_q);
  assign o_match = w_cmp && w_eq;
  assign o_late  = w_cmp && !w_eq && (lat_q == c_last);
  assign o_lat   = lat_q + c_lat_w'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      lat_q   <= '0;
    end else if (i_clr) begin
      state_q <= IDLE;
      lat_q   <= '0;
    end else if (i_store) begin
      state_q <= WAIT;
      data_q  <= i_wdata;
      lat_q   <= '0;
    end else begin
      case (state_q)
        WAIT: begin
          if (o_match || o_late) begin
            state_q <= IDLE;
            lat_q   <= '0;
          end else begin
            lat_q <= lat_q + c_lat_w'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule : mmio_chk_chan

`default_nettype wire

// File: rtl/mmio_latency_checker.sv
// ============================================================================
// Module      : mmio_latency_checker
// Description : Checks that MMIO stores reach the peripheral outputs within a
//               settle window, and counts fetches / flags misaligned PCs.
// Ports       : i_clk, i_rst_n                  clock / async active-low reset
//               i_lsu_we, i_lsu_addr, i_lsu_wdata store interface
//               i_ch_obs                         observed outputs, DATA_W/ch
//               i_pc, i_insn_vld                 fetch stream
//               i_clr                            clear flags/counters/checks
//               o_ch_late, o_ch_hit              sticky per-channel flags
//               o_late_cnt, o_insn_cnt           saturating counters
//               o_worst_lat                      largest settle latency
//               o_pc_misalign, o_err_pulse       sticky flag / error strobe
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_latency_checker
  import mmio_chk_pkg::*;
#(
  parameter int          NUM_CH    = 2,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] BASE_ADDR = c_def_base_addr,
  parameter logic [31:0] STRIDE    = c_def_stride,
  parameter int          MAX_LAT   = 4,
  parameter int          CNT_W     = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_lsu_we,
  input  logic [31:0]              i_lsu_addr,
  input  logic [DATA_W-1:0]        i_lsu_wdata,
  input  logic [NUM_CH*DATA_W-1:0] i_ch_obs,
  input  logic [31:0]              i_pc,
  input  logic                     i_insn_vld,
  input  logic                     i_clr,
  output logic [NUM_CH-1:0]        o_ch_late,
  output logic [NUM_CH-1:0]        o_ch_hit,
  output logic [CNT_W-1:0]         o_late_cnt,
  output logic [CNT_W-1:0]         o_insn_cnt,
  output logic [c_lat_w-1:0]       o_worst_lat,
  output logic                     o_pc_misalign,
  output logic                     o_err_pulse
);

  logic [NUM_CH-1:0]  w_store;
  logic [NUM_CH-1:0]  w_match;
  logic [NUM_CH-1:0]  w_late;
  logic [c_lat_w-1:0] w_lat [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    localparam logic [31:0] c_addr = BASE_ADDR + STRIDE * gi;

    assign w_store[gi] = i_lsu_we && (i_lsu_addr == c_addr);

    mmio_chk_chan #(
      .DATA_W  (DATA_W),
      .MAX_LAT (MAX_LAT)
    ) u_chan (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (i_clr),
      .i_store (w_store[gi]),
      .i_wdata (i_lsu_wdata),
      .i_obs   (i_ch_obs[gi*DATA_W +: DATA_W]),
      .o_match (w_match[gi]),
      .o_late  (w_late[gi]),
      .o_lat   (w_lat[gi])
    );
  end

  logic [NUM_CH-1:0]  ch_late_q, ch_hit_q;
  logic [CNT_W-1:0]   late_cnt_q, insn_cnt_q;
  logic [c_lat_w-1:0] worst_q;
  logic               misalign_q, err_q;

  logic [CNT_W:0]     w_late_sum;
  logic [CNT_W-1:0]   w_late_cnt_d;
  logic [CNT_W-1:0]   w_insn_cnt_d;
  logic [c_lat_w-1:0] w_worst_d;
  logic               w_misalign;
  logic               w_pc_unused;

  // Only the low PC bits matter for the alignment check.
  assign w_pc_unused = ^i_pc[31:2];
  assign w_misalign  = i_insn_vld && (i_pc[1:0] != 2'b00);

  always_comb begin
    // One extra bit catches overflow when several channels time out at once.
    w_late_sum = {1'b0, late_cnt_q};
    w_worst_d  = worst_q;
    for (int i = 0; i < NUM_CH; i++) begin
      w_late_sum = w_late_sum + {{CNT_W{1'b0}}, w_late[i]};
      if (w_match[i] && (w_lat[i] > w_worst_d)) begin
        w_worst_d = w_lat[i];
      end
    end
    w_late_cnt_d = w_late_sum[CNT_W] ? {CNT_W{1'b1}} : w_late_sum[CNT_W-1:0];
    w_insn_cnt_d = (&insn_cnt_q) ? insn_cnt_q : insn_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ch_late_q  <= '0;
      ch_hit_q   <= '0;
      late_cnt_q <= '0;
      insn_cnt_q <= '0;
      worst_q    <= '0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (i_clr) begin
      ch_late_q  <= '0;
      ch_hit_q   <= '0;
      late_cnt_q <= '0;
      insn_cnt_q <= '0;
      worst_q    <= '0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ch_late_q  <= ch_late_q | w_late;
      ch_hit_q   <= ch_hit_q | w_match;
      late_cnt_q <= w_late_cnt_d;
      worst_q    <= w_worst_d;
      if (i_insn_vld) begin
        insn_cnt_q <= w_insn_cnt_d;
      end
      if (w_misalign) begin
        misalign_q <= 1'b1;
      end
      // One pulse per edge no matter how many error sources fired.
      err_q <= (|w_late) || (w_misalign && !misalign_q);
    end
  end

  assign o_ch_late     = ch_late_q;
  assign o_ch_hit      = ch_hit_q;
  assign o_late_cnt    = late_cnt_q;
  assign o_insn_cnt    = insn_cnt_q;
  assign o_worst_lat   = worst_q;
  assign o_pc_misalign = misalign_q;
  assign o_err_pulse   = err_q;

endmodule : mmio_latency_checker

`default_nettype wire
